seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a row of common-cathode 7-segment digits that share one BCD-to-7-segment decoder. Each cycle it selects one digit and drives that digit's nibble onto the shared decoder input `bcd`. It also drives the matching one-hot digit enable, with a blanking gap at the start of each slot to prevent ghosting. New display values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_ctrl.sv | 94 +++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder,
// per-slot blanking, optional leading-zero blanking and frame-aligned updates.
module seven_seg_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] data_in,
    input  logic              lz_en,
    output logic [3:0]        bcd,
    output logic [NDIG-1:0]   dig_en,
    output logic              frame_start,
    output logic              ld_ack,
    output logic              pending
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LIT  = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] shadow;
    logic [4*NDIG-1:0] active;
    logic              slot_end;
    logic              frame_edge;
    logic              lit;
    logic              zero_run;
    logic [NDIG-1:0]   sel;
    logic [NDIG-1:0]   sup;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_edge = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            ld_ack      <= 1'b0;
        end else begin
            cnt         <= slot_end ? '0 : cnt + CW'(1);
            frame_start <= frame_edge;
            ld_ack      <= frame_edge && pending;
            if (slot_end) begin
                idx <= frame_edge ? '0 : idx + IW'(1);
            end
            // transfer reads the old shadow even when a load lands on this edge
            if (frame_edge && pending) begin
                active <= shadow;
            end
            if (load) begin
                shadow  <= data_in;
                pending <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end
        end
    end

    // walk from the top digit down; a digit is blank while everything above it is zero
    always_comb begin
        bcd      = '0;
        sel      = '0;
        sup      = '0;
        zero_run = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_run = zero_run && (active[4*i +: 4] == 4'd0);
            sup[i]   = lz_en && zero_run && (i != 0);
            if (idx == IW'(i)) begin
                sel[i] = 1'b1;
                bcd    = active[4*i +: 4];
            end
        end
    end

    generate
        if (BLANK == 0) begin : g_noblank
            assign lit = 1'b1;
        end else begin : g_blank
            assign lit = (cnt >= CNT_LIT);
        end
    endgenerate

    assign dig_en = (lit && !(|(sel & sup))) ? sel : '0;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenario tables plus random
// loads/lz/reset against a cycle-count based reference model.
module tb_seven_seg_scan_ctrl;
    localparam int N = 4;
    localparam int P = 4;
    localparam int B = 1;
    localparam int F = N * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  bcd;
    logic [3:0]  dig_en;
    logic        frame_start;
    logic        ld_ack;
    logic        pending;

    seven_seg_scan_ctrl #(.NDIG(N), .PRESCALE(P), .BLANK(B)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .lz_en(lz_en),
        .bcd(bcd), .dig_en(dig_en), .frame_start(frame_start),
        .ld_ack(ld_ack), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ncyc;
        logic        lz;
        int          l0;
        logic [15:0] d0;
        int          l1;
        logic [15:0] d1;
        int          rc;
    } scen_t;

    typedef struct {
        int sc;
        int cyc;
        int bcd;
        int den;
        int fs;
        int ack;
        int pend;
    } exp_t;

    int errors = 0;
    int checks = 0;
    int t;
    int cur_sc;
    logic [15:0] m_shadow, m_active;
    logic        m_pend, m_ack, m_fs;
    scen_t       scens[6];
    exp_t        dir[$];

    function automatic logic [10:0] outs();
        return {bcd, dig_en, frame_start, ld_ack, pending};
    endfunction

    // expected enable from slot position and the highest non-zero digit
    function automatic logic [3:0] ref_den(input int tt, input logic [15:0] act, input logic lz);
        int slot = (tt / P) % N;
        int pos  = tt % P;
        int top  = -1;
        for (int i = 0; i < N; i++)
            if (((act >> (4 * i)) & 16'hF) != 16'h0) top = i;
        if (pos < B) return 4'h0;
        if (lz && slot > 0 && slot > top) return 4'h0;
        return 4'(1 << slot);
    endfunction

    task automatic chk(input string nm, input logic [10:0] got,
                       input logic [10:0] want, input logic [10:0] msk);
        checks++;
        if ((got & msk) !== (want & msk)) begin
            errors++;
            $display("FAIL %s t=%0d got bcd=%h en=%b fs=%b ack=%b pend=%b want bcd=%h en=%b fs=%b ack=%b pend=%b mask=%b",
                     nm, t, got[10:7], got[6:3], got[2], got[1], got[0],
                     want[10:7], want[6:3], want[2], want[1], want[0], msk);
        end
    endtask

    task automatic add(input int sc, input int cyc, input int b, input int d,
                       input int f, input int a, input int p);
        exp_t e;
        e = '{sc, cyc, b, d, f, a, p};
        dir.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        data_in = 16'h0;
        #1;
        chk("reset_now", outs(), 11'h0, '1);
        @(posedge clk);
        #1;
        chk("reset_hold", outs(), 11'h0, '1);
        rst = 1'b0;
        t = 0;
        m_shadow = 16'h0;
        m_active = 16'h0;
        m_pend = 1'b0;
        m_ack = 1'b0;
        m_fs = 1'b0;
    endtask

    task automatic cycle(input logic ld, input logic [15:0] d, input logic lz);
        logic [10:0] w, w2, m2;
        logic        edge_c;
        load = ld;
        data_in = d;
        lz_en = lz;
        #1;
        w = {4'((m_active >> (4 * ((t / P) % N))) & 16'hF),
             ref_den(t, m_active, lz), m_fs, m_ack, m_pend};
        chk("model", outs(), w, '1);
        foreach (dir[k]) begin
            if (dir[k].sc == cur_sc && dir[k].cyc == t) begin
                w2 = {4'(dir[k].bcd), 4'(dir[k].den), dir[k].fs[0], dir[k].ack[0], dir[k].pend[0]};
                m2 = {(dir[k].bcd < 0) ? 4'h0 : 4'hF, (dir[k].den < 0) ? 4'h0 : 4'hF,
                      dir[k].fs >= 0, dir[k].ack >= 0, dir[k].pend >= 0};
                chk($sformatf("scen%0d_c%0d", cur_sc, t), outs(), w2, m2);
            end
        end
        @(posedge clk);
        #1;
        edge_c = (t % F == F - 1);
        m_ack = edge_c && m_pend;
        m_fs = edge_c;
        if (edge_c && m_pend) m_active = m_shadow;
        if (ld) begin
            m_shadow = d;
            m_pend = 1'b1;
        end else if (edge_c) begin
            m_pend = 1'b0;
        end
        t++;
    endtask

    initial begin
        logic [3:0] slot_en[16];
        logic       lz_r;
        slot_en = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8};

        scens[0] = '{33, 1'b0, -1, 16'h0000, -1, 16'h0000, -1};
        scens[1] = '{32, 1'b0,  5, 16'h1234, -1, 16'h0000, -1};
        scens[2] = '{34, 1'b0,  3, 16'h1111,  9, 16'h2222, -1};
        scens[3] = '{40, 1'b0,  8, 16'h9999, 15, 16'h5678, -1};
        scens[4] = '{40, 1'b1,  0, 16'h0070, 20, 16'h0000, -1};
        scens[5] = '{30, 1'b0,  2, 16'hABCD, -1, 16'h0000, 10};

        for (int c = 0; c < 16; c++) add(0, c, 0, int'(slot_en[c]), -1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 16, 0, 0, 1, 0, 0);
        add(0, 17, 0, 1, 0, 0, 0);
        add(0, 32, 0, 0, 1, 0, 0);
        add(1, 5, -1, -1, -1, -1, 0);
        add(1, 6, -1, -1, -1, 0, 1);
        add(1, 16, 4, 0, 1, 1, 0);
        add(1, 17, 4, 1, 0, 0, 0);
        add(1, 21, 3, 2, -1, -1, -1);
        add(1, 25, 2, 4, -1, -1, -1);
        add(1, 29, 1, 8, -1, -1, -1);
        add(2, 16, 2, 0, 1, 1, 0);
        add(2, 17, -1, -1, -1, 0, -1);
        add(2, 28, 2, -1, -1, -1, -1);
        add(2, 32, 2, -1, 1, 0, 0);
        add(3, 16, 9, 0, 1, 1, 1);
        add(3, 32, 8, 0, 1, 1, 0);
        add(3, 36, 7, 0, -1, 0, 0);
        add(4, 17, 0, 1, -1, -1, -1);
        add(4, 21, 7, 2, -1, -1, -1);
        add(4, 25, 0, 0, -1, -1, -1);
        add(4, 29, 0, 0, -1, -1, -1);
        add(4, 33, 0, 1, -1, -1, -1);
        add(4, 37, 0, 0, -1, -1, -1);
        add(5, 12, 0, 0, 0, 0, 0);
        add(5, 13, 0, 8, 0, 0, 0);
        add(5, 16, 0, 0, 1, 0, 0);
        add(5, 17, 0, 1, 0, 0, 0);

        for (int s = 0; s < 6; s++) begin
            cur_sc = s;
            do_reset();
            for (int c = 0; c < scens[s].ncyc; c++) begin
                if (c == scens[s].rc) do_reset();
                if (c == scens[s].l0) cycle(1'b1, scens[s].d0, scens[s].lz);
                else if (c == scens[s].l1) cycle(1'b1, scens[s].d1, scens[s].lz);
                else cycle(1'b0, 16'h0, scens[s].lz);
            end
        end

        cur_sc = 6;
        do_reset();
        lz_r = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) lz_r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 249) == 0) do_reset();
            if ($urandom_range(0, 9) == 0)
                cycle(1'b1, ($urandom_range(0, 2) == 0) ? 16'(16'h00F0 & $urandom) : 16'($urandom), lz_r);
            else
                cycle(1'b0, 16'($urandom), lz_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
